// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch -> decode instruction path.
package fetch_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [31:2]     instr;
    logic [XLEN-1:0] curr_pc;
    logic [XLEN-1:0] inc_pc;
  } fetch_entry_t;

  // addi x0, x0, 0 with the two low opcode bits stripped
  localparam logic [31:2] NOP_INSTR = 30'h4;

  // Opcode bits [6:2] of the control-flow instruction classes
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  function automatic logic is_jump_op(input logic [4:0] op);
    return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
interface fetch_buffer_if
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  localparam int CW = $clog2(DEPTH + 1);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:2]     in_instr;
  logic [XLEN-1:0] in_curr_pc;
  logic [XLEN-1:0] in_inc_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:2]     out_instr;
  logic [XLEN-1:0] out_curr_pc;
  logic [XLEN-1:0] out_inc_pc;
  logic            out_is_jump;
  logic [CW-1:0]   count;

  // Queue side
  modport slave (
    input  flush, in_valid, in_instr, in_curr_pc, in_inc_pc, out_ready,
    output in_ready, out_valid, out_instr, out_curr_pc, out_inc_pc,
           out_is_jump, count
  );

  // Producer/consumer side (fetch unit, decode, or a bench)
  modport master (
    output flush, in_valid, in_instr, in_curr_pc, in_inc_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_curr_pc, out_inc_pc,
           out_is_jump, count
  );

endinterface

// File: rtl/fetch_buffer.sv
// Circular instruction queue between fetch and decode. Registered output
// (no bypass), flush on redirect, control-flow flag on the head entry.
// Datapath width comes from fetch_pkg::XLEN so the entry type stays shared.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  fetch_buffer_if.slave  bus
);

  localparam int            PW   = $clog2(DEPTH);
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  head;
  logic          in_ready, out_valid, push, pop;

  // Handshake and next pointer/count; flush overrides any push or pop
  always_comb begin
    in_ready  = (count_q != FULL) && !bus.flush;
    out_valid = (count_q != '0);
    push      = bus.in_valid && in_ready;
    pop       = out_valid && bus.out_ready;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; reset empties the queue like a flush
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are left alone on reset since count gates them
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{instr:   bus.in_instr,
                           curr_pc: bus.in_curr_pc,
                           inc_pc:  bus.in_inc_pc};
    end
  end

  // Head entry presented to decode, forced to a NOP bubble when empty
  always_comb begin
    head            = mem_q[rd_ptr_q];
    bus.in_ready    = in_ready;
    bus.out_valid   = out_valid;
    bus.count       = count_q;
    bus.out_instr   = NOP_INSTR;
    bus.out_curr_pc = '0;
    bus.out_inc_pc  = '0;
    bus.out_is_jump = 1'b0;
    if (out_valid) begin
      bus.out_instr   = head.instr;
      bus.out_curr_pc = head.curr_pc;
      bus.out_inc_pc  = head.inc_pc;
      bus.out_is_jump = is_jump_op(head.instr[6:2]);
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed-vector bench for fetch_buffer (DEPTH = 4).
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam logic [4:0] A  = 5'b00100;  // ADDI
  localparam logic [4:0] J  = 5'b11011;  // JAL
  localparam logic [4:0] JR = 5'b11001;  // JALR
  localparam logic [4:0] B  = 5'b11000;  // BRANCH

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  fetch_buffer_if #(.DEPTH(4)) bus ();

  fetch_buffer #(.DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          rn, fl, iv, ordy, chk;
    logic [31:0] pc, inc;
    logic [4:0]  op;
    int          ecnt;
    logic [31:0] epc, einc;
    logic [4:0]  eop;
    bit          ej;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:2] mk(input logic [31:0] pc, input logic [4:0] op);
    return {pc[24:0], op};
  endfunction

  task automatic v(input bit rn, fl, iv, input logic [31:0] pc, inc,
                   input logic [4:0] op, input bit ordy, input int ecnt,
                   input logic [31:0] epc, einc, input logic [4:0] eop,
                   input bit ej);
    vec_t t;
    t.rn = rn; t.fl = fl; t.iv = iv; t.pc = pc; t.inc = inc; t.op = op;
    t.ordy = ordy; t.chk = 1'b1; t.ecnt = ecnt; t.epc = epc; t.einc = einc;
    t.eop = eop; t.ej = ej;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [127:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    logic [127:0] got, exp;
    bit           ev, eir;
    int           lat;

    reset_n = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0;
    bus.in_curr_pc = '0; bus.in_inc_pc = '0; bus.out_ready = 1'b0;

    // reset held two clocks, then idle
    v(0,0,0, 0,0,A,0, 0, 0,0,A,0);
    v(0,0,0, 0,0,A,0, 0, 0,0,A,0);
    v(1,0,0, 0,0,A,0, 0, 0,0,A,0);
    // fill to DEPTH, 5th entry held off until one pop
    v(1,0,1, 'h0,'h4,A,0,   0, 0,0,A,0);
    v(1,0,1, 'h4,'h8,A,0,   1, 'h0,'h4,A,0);
    v(1,0,1, 'h8,'hC,A,0,   2, 'h0,'h4,A,0);
    v(1,0,1, 'hC,'h10,A,0,  3, 'h0,'h4,A,0);
    v(1,0,1, 'h10,'h14,A,0, 4, 'h0,'h4,A,0);
    v(1,0,1, 'h10,'h14,A,1, 4, 'h0,'h4,A,0);
    v(1,0,1, 'h10,'h14,A,0, 3, 'h4,'h8,A,0);
    v(1,0,0, 0,0,A,1,       4, 'h4,'h8,A,0);
    v(1,0,0, 0,0,A,1,       3, 'h8,'hC,A,0);
    v(1,0,0, 0,0,A,1,       2, 'hC,'h10,A,0);
    v(1,0,0, 0,0,A,1,       1, 'h10,'h14,A,0);
    v(1,0,0, 0,0,A,0,       0, 0,0,A,0);
    // continuous stream from empty
    v(1,0,1, 'h0,'h4,A,1,   0, 0,0,A,0);
    v(1,0,1, 'h4,'h8,A,1,   1, 'h0,'h4,A,0);
    v(1,0,1, 'h8,'hC,A,1,   1, 'h4,'h8,A,0);
    v(1,0,1, 'hC,'h10,A,1,  1, 'h8,'hC,A,0);
    v(1,0,0, 0,0,A,1,       1, 'hC,'h10,A,0);
    v(1,0,0, 0,0,A,0,       0, 0,0,A,0);
    // interleaved across pointer wrap, compressed entry 0x112 -> 0x114
    v(1,0,1, 'h100,'h104,A,0, 0, 0,0,A,0);
    v(1,0,1, 'h104,'h108,A,0, 1, 'h100,'h104,A,0);
    v(1,0,1, 'h108,'h10C,A,1, 2, 'h100,'h104,A,0);
    v(1,0,1, 'h10C,'h110,A,1, 2, 'h104,'h108,A,0);
    v(1,0,1, 'h110,'h112,A,1, 2, 'h108,'h10C,A,0);
    v(1,0,1, 'h112,'h114,A,0, 2, 'h10C,'h110,A,0);
    v(1,0,1, 'h114,'h118,A,1, 3, 'h10C,'h110,A,0);
    v(1,0,1, 'h118,'h11C,A,1, 3, 'h110,'h112,A,0);
    v(1,0,1, 'h11C,'h120,A,1, 3, 'h112,'h114,A,0);
    v(1,0,1, 'h120,'h124,A,1, 3, 'h114,'h118,A,0);
    v(1,0,0, 0,0,A,1,         3, 'h118,'h11C,A,0);
    v(1,0,0, 0,0,A,1,         2, 'h11C,'h120,A,0);
    v(1,0,0, 0,0,A,1,         1, 'h120,'h124,A,0);
    v(1,0,0, 0,0,A,0,         0, 0,0,A,0);
    // flush at count 3 with a simultaneous push of 0x20
    v(1,0,1, 'h200,'h204,A,0, 0, 0,0,A,0);
    v(1,0,1, 'h204,'h208,A,0, 1, 'h200,'h204,A,0);
    v(1,0,1, 'h208,'h20C,A,0, 2, 'h200,'h204,A,0);
    v(1,1,1, 'h20,'h24,A,0,   3, 'h200,'h204,A,0);
    v(1,0,0, 0,0,A,0,         0, 0,0,A,0);
    v(1,0,1, 'h40,'h44,A,0,   0, 0,0,A,0);
    v(1,0,1, 'h44,'h48,A,0,   1, 'h40,'h44,A,0);
    v(1,0,0, 0,0,A,1,         2, 'h40,'h44,A,0);
    v(1,0,0, 0,0,A,1,         1, 'h44,'h48,A,0);
    v(1,0,0, 0,0,A,0,         0, 0,0,A,0);
    // control-flow flag at the head
    v(1,0,1, 'h300,'h304,J,0,  0, 0,0,A,0);
    v(1,0,1, 'h304,'h308,A,0,  1, 'h300,'h304,J,1);
    v(1,0,0, 0,0,A,1,          2, 'h300,'h304,J,1);
    v(1,0,0, 0,0,A,1,          1, 'h304,'h308,A,0);
    v(1,0,1, 'h308,'h30C,JR,0, 0, 0,0,A,0);
    v(1,0,1, 'h30C,'h310,B,0,  1, 'h308,'h30C,JR,1);
    v(1,0,0, 0,0,A,1,          2, 'h308,'h30C,JR,1);
    v(1,0,0, 0,0,A,1,          1, 'h30C,'h310,B,1);
    v(1,0,0, 0,0,A,0,          0, 0,0,A,0);
    // reset mid-stream with a push in the same cycle
    v(1,0,1, 'h400,'h404,A,0, 0, 0,0,A,0);
    v(1,0,1, 'h404,'h408,A,0, 1, 'h400,'h404,A,0);
    v(0,0,1, 'h408,'h40C,A,0, 2, 'h400,'h404,A,0);
    v(1,0,0, 0,0,A,0,         0, 0,0,A,0);
    v(1,0,1, 'h500,'h504,A,0, 0, 0,0,A,0);
    v(1,0,0, 0,0,A,0,         1, 'h500,'h504,A,0);
    v(1,0,0, 0,0,A,1,         1, 'h500,'h504,A,0);
    v(1,0,0, 0,0,A,0,         0, 0,0,A,0);
    vecs[0].chk = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      reset_n        = vecs[i].rn;
      bus.flush      = vecs[i].fl;
      bus.in_valid   = vecs[i].iv;
      bus.in_curr_pc = vecs[i].pc;
      bus.in_inc_pc  = vecs[i].inc;
      bus.in_instr   = mk(vecs[i].pc, vecs[i].op);
      bus.out_ready  = vecs[i].ordy;
      #1;
      if (vecs[i].chk) begin
        ev  = (vecs[i].ecnt != 0);
        eir = (vecs[i].ecnt != 4) && !vecs[i].fl;
        got = {bus.out_valid, bus.in_ready, bus.count, bus.out_is_jump,
               bus.out_instr, bus.out_curr_pc, bus.out_inc_pc};
        exp = {ev, eir, 3'(vecs[i].ecnt), vecs[i].ej,
               (ev ? mk(vecs[i].epc, vecs[i].eop) : NOP_INSTR),
               vecs[i].epc, vecs[i].einc};
        check($sformatf("row%0d", i), got, exp);
      end
    end

    // single push into empty queue is visible exactly one edge later
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_curr_pc = 32'h600; bus.in_inc_pc = 32'h604;
    bus.in_instr = mk(32'h600, A); bus.out_ready = 1'b0;
    #1;
    check("no_bypass", {127'd0, bus.out_valid}, 128'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 5) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 128'(lat), 128'd0);
    check("lat_pc", {96'd0, bus.out_curr_pc}, 128'h600);

    // flush together with a pop empties the queue
    @(negedge clk);
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    #1;
    check("flush_ready", {127'd0, bus.in_ready}, 128'd0);
    @(negedge clk);
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    #1;
    check("flush_pop", {bus.out_valid, bus.count, bus.out_instr},
          {1'b0, 3'd0, NOP_INSTR});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
